// File: rtl/collision_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : collision_scan_if
// Description : Bundle between the frame controller, the entity/obstacle
//               state registers and the collision scan engine. Carries the
//               start request, box geometry and the published results.
// Revision    : 1.0 - initial release
// ============================================================================
interface collision_scan_if #(
  parameter int N_ENT   = 2,
  parameter int N_OBS   = 16,
  parameter int COORD_W = 10,
  parameter int RAD_W   = 8
);
  localparam int OIDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;

  logic               start;
  logic [COORD_W-1:0] entX  [N_ENT];
  logic [COORD_W-1:0] entY  [N_ENT];
  logic [RAD_W-1:0]   entRX [N_ENT];
  logic [RAD_W-1:0]   entRY [N_ENT];
  logic [COORD_W-1:0] obsX  [N_OBS];
  logic [COORD_W-1:0] obsY  [N_OBS];
  logic [RAD_W-1:0]   obsRX [N_OBS];
  logic [RAD_W-1:0]   obsRY [N_OBS];
  logic [N_OBS-1:0]   obsExists;
  logic               busy;
  logic               done;
  logic               overrun;
  logic [N_ENT-1:0]   hitMask;
  logic [OIDX_W-1:0]  firstHit [N_ENT];

  // Frame controller / geometry source side
  modport master (
    output start, entX, entY, entRX, entRY, obsX, obsY, obsRX, obsRY, obsExists,
    input  busy, done, overrun, hitMask, firstHit
  );

  // Scan engine side
  modport slave (
    input  start, entX, entY, entRX, entRY, obsX, obsY, obsRX, obsRY, obsExists,
    output busy, done, overrun, hitMask, firstHit
  );
endinterface
`default_nettype wire

// File: rtl/collision_scan_engine.sv
`default_nettype none
// ============================================================================
// Module      : collision_scan_engine
// Description : Time-multiplexed N-entity x M-obstacle axis-aligned box
//               collision scanner. One shared comparator tests one
//               (entity, obstacle) pair per clock, entity-major, and the
//               per-entity hit mask / lowest hit index are committed
//               atomically at the end of the scan.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scan_engine #(
  parameter int N_ENT   = 2,
  parameter int N_OBS   = 16,
  parameter int COORD_W = 10,
  parameter int RAD_W   = 8,
  parameter int STRICT  = 0
) (
  input  wire logic           sysClk,
  input  wire logic           reset_l,
  collision_scan_if.slave     bus
);
  localparam int OIDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
  localparam int EIDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  // Comparator width wide enough for both a coordinate and a radius sum.
  localparam int CMP_W  = (COORD_W > RAD_W + 1) ? COORD_W : RAD_W + 1;

  localparam logic [OIDX_W-1:0] c_OBS_LAST = OIDX_W'(N_OBS - 1);
  localparam logic [EIDX_W-1:0] c_ENT_LAST = EIDX_W'(N_ENT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic               w_accept;
  logic               w_scanning;
  logic               w_lastPair;

  logic [EIDX_W-1:0]  r_eIdx;
  logic [OIDX_W-1:0]  r_oIdx;

  logic [N_ENT-1:0]   r_wMask;
  logic [N_ENT-1:0]   w_wMaskNext;
  logic [OIDX_W-1:0]  r_wFirst     [N_ENT];
  logic [OIDX_W-1:0]  w_wFirstNext [N_ENT];

  logic [N_ENT-1:0]   r_hitMask;
  logic [OIDX_W-1:0]  r_firstHit   [N_ENT];
  logic               r_overrun;

  logic [CMP_W-1:0]   w_ex, w_ey, w_ox, w_oy;
  logic [CMP_W-1:0]   w_dx, w_dy;
  logic [RAD_W:0]     w_rsumX, w_rsumY;
  logic [CMP_W-1:0]   w_sumRX, w_sumRY;
  logic               w_xHit, w_yHit, w_pairHit;

  assign w_scanning = (r_state == S_SCAN);
  assign w_lastPair = w_scanning && (r_eIdx == c_ENT_LAST) && (r_oIdx == c_OBS_LAST);

  // ---------------------------------------------------------------------------
  // Shared pair comparator. Distances use compare-then-subtract so they never
  // wrap, and the radius sum carries one extra bit so 255+255 stays exact.
  // ---------------------------------------------------------------------------
  assign w_ex = CMP_W'(bus.entX[r_eIdx]);
  assign w_ey = CMP_W'(bus.entY[r_eIdx]);
  assign w_ox = CMP_W'(bus.obsX[r_oIdx]);
  assign w_oy = CMP_W'(bus.obsY[r_oIdx]);

  assign w_dx = (w_ex >= w_ox) ? (w_ex - w_ox) : (w_ox - w_ex);
  assign w_dy = (w_ey >= w_oy) ? (w_ey - w_oy) : (w_oy - w_ey);

  assign w_rsumX = {1'b0, bus.entRX[r_eIdx]} + {1'b0, bus.obsRX[r_oIdx]};
  assign w_rsumY = {1'b0, bus.entRY[r_eIdx]} + {1'b0, bus.obsRY[r_oIdx]};
  assign w_sumRX = CMP_W'(w_rsumX);
  assign w_sumRY = CMP_W'(w_rsumY);

  assign w_xHit = (STRICT != 0) ? (w_dx < w_sumRX) : (w_dx <= w_sumRX);
  assign w_yHit = (STRICT != 0) ? (w_dy < w_sumRY) : (w_dy <= w_sumRY);

  assign w_pairHit = w_scanning && w_xHit && w_yHit && bus.obsExists[r_oIdx];

  // Working-result update for the pair under test; the first hit per entity wins.
  always_comb begin
    w_wMaskNext  = r_wMask;
    w_wFirstNext = r_wFirst;
    if (w_pairHit) begin
      if (!r_wMask[r_eIdx]) begin
        w_wFirstNext[r_eIdx] = r_oIdx;
      end
      w_wMaskNext[r_eIdx] = 1'b1;
    end
  end

  // Next-state logic; a start arriving in DONE chains straight into a new scan.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_lastPair) begin
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_stateNext = S_SCAN;
        end else begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sysClk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Pair counters and working results: cleared on accept, stepped while scanning,
  // frozen on the last pair so nothing wraps past the end of the scan.
  always_ff @(posedge sysClk or negedge reset_l) begin
    if (!reset_l) begin
      r_eIdx  <= '0;
      r_oIdx  <= '0;
      r_wMask <= '0;
      for (int i = 0; i < N_ENT; i++) begin
        r_wFirst[i] <= '0;
      end
    end else if (w_accept) begin
      r_eIdx  <= '0;
      r_oIdx  <= '0;
      r_wMask <= '0;
      for (int i = 0; i < N_ENT; i++) begin
        r_wFirst[i] <= '0;
      end
    end else if (w_scanning) begin
      r_wMask  <= w_wMaskNext;
      r_wFirst <= w_wFirstNext;
      if (!w_lastPair) begin
        if (r_oIdx == c_OBS_LAST) begin
          r_oIdx <= '0;
          r_eIdx <= r_eIdx + 1'b1;
        end else begin
          r_oIdx <= r_oIdx + 1'b1;
        end
      end
    end
  end

  // Published results change only on the commit edge, including the last pair.
  always_ff @(posedge sysClk or negedge reset_l) begin
    if (!reset_l) begin
      r_hitMask <= '0;
      for (int i = 0; i < N_ENT; i++) begin
        r_firstHit[i] <= '0;
      end
    end else if (w_lastPair) begin
      r_hitMask  <= w_wMaskNext;
      r_firstHit <= w_wFirstNext;
    end
  end

  // One-cycle overrun flag for a start that lands while a scan is running.
  always_ff @(posedge sysClk or negedge reset_l) begin
    if (!reset_l) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= bus.start && w_scanning;
    end
  end

  assign bus.busy     = w_scanning;
  assign bus.done     = (r_state == S_DONE);
  assign bus.overrun  = r_overrun;
  assign bus.hitMask  = r_hitMask;
  assign bus.firstHit = r_firstHit;

endmodule
`default_nettype wire

// File: tb/tb_collision_scan_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_scan_engine
// Description : Self-checking bench for collision_scan_engine. Two 1x1
//               instances cover inclusive/strict edge touching; a 2x16
//               instance is checked against a scoreboard of expected
//               results built from an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scan_engine;

  logic sysClk  = 1'b0;
  logic reset_l = 1'b0;
  int   cyc     = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  localparam int K_C = 32;

  typedef struct {
    logic [1:0] mask;
    int         f0;
    int         f1;
    int         doneCyc;
  } exp_t;

  exp_t sbq[$];
  exp_t monExp;

  collision_scan_if #(.N_ENT(1), .N_OBS(1),  .COORD_W(10), .RAD_W(8)) ifA();
  collision_scan_if #(.N_ENT(1), .N_OBS(1),  .COORD_W(10), .RAD_W(8)) ifB();
  collision_scan_if #(.N_ENT(2), .N_OBS(16), .COORD_W(10), .RAD_W(8)) ifC();

  collision_scan_engine #(.N_ENT(1), .N_OBS(1), .COORD_W(10), .RAD_W(8), .STRICT(0))
    dutA (.sysClk(sysClk), .reset_l(reset_l), .bus(ifA));
  collision_scan_engine #(.N_ENT(1), .N_OBS(1), .COORD_W(10), .RAD_W(8), .STRICT(1))
    dutB (.sysClk(sysClk), .reset_l(reset_l), .bus(ifB));
  collision_scan_engine #(.N_ENT(2), .N_OBS(16), .COORD_W(10), .RAD_W(8), .STRICT(0))
    dutC (.sysClk(sysClk), .reset_l(reset_l), .bus(ifC));

  always #5 sysClk = ~sysClk;

  always @(posedge sysClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Integer reference model for the 2x16 inclusive instance.
  function automatic exp_t modelC();
    exp_t r;
    r.mask = 2'b00; r.f0 = 0; r.f1 = 0; r.doneCyc = 0;
    for (int e = 0; e < 2; e++) begin
      bit found;
      int first, dx, dy, sx, sy;
      found = 1'b0;
      first = 0;
      for (int o = 0; o < 16; o++) begin
        dx = int'(ifC.entX[e]) - int'(ifC.obsX[o]);
        dy = int'(ifC.entY[e]) - int'(ifC.obsY[o]);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        sx = int'(ifC.entRX[e]) + int'(ifC.obsRX[o]);
        sy = int'(ifC.entRY[e]) + int'(ifC.obsRY[o]);
        if (dx <= sx && dy <= sy && ifC.obsExists[o] && !found) begin
          found = 1'b1;
          first = o;
        end
      end
      r.mask[e] = found;
      if (e == 0) r.f0 = first; else r.f1 = first;
    end
    return r;
  endfunction

  task automatic setEnt(input int e, input int x, input int y, input int r);
    ifC.entX[e]  = 10'(x);
    ifC.entY[e]  = 10'(y);
    ifC.entRX[e] = 8'(r);
    ifC.entRY[e] = 8'(r);
  endtask

  task automatic setObs(input int o, input int x, input int y, input int r);
    ifC.obsX[o]  = 10'(x);
    ifC.obsY[o]  = 10'(y);
    ifC.obsRX[o] = 8'(r);
    ifC.obsRY[o] = 8'(r);
  endtask

  task automatic farObs();
    for (int o = 0; o < 16; o++) setObs(o, 1000, 1000, 1);
    ifC.obsExists = 16'hFFFF;
  endtask

  // Called while sitting on a negedge: raises start for one edge, records the
  // accept edge and pushes the expected result.
  task automatic startC();
    exp_t e;
    ifC.start = 1'b1;
    @(posedge sysClk);
    #1;
    ifC.start = 1'b0;
    e = modelC();
    e.doneCyc = cyc + K_C;
    sbq.push_back(e);
  endtask

  task automatic waitDoneC(input string tag, input bit hold, input int hm,
                           input int f0, input int f1);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge sysClk);
      if (ifC.done) begin
        seen = 1'b1;
      end else if (hold) begin
        chk({tag, "_holdMask"}, int'(ifC.hitMask), hm);
        chk({tag, "_holdF0"},   int'(ifC.firstHit[0]), f0);
        chk({tag, "_holdF1"},   int'(ifC.firstHit[1]), f1);
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  // Scoreboard side: every done pulse must match the oldest pending expectation.
  always @(negedge sysClk) begin
    if (reset_l && ifC.done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        monExp = sbq.pop_front();
        chk("sb_mask",    int'(ifC.hitMask), int'(monExp.mask));
        chk("sb_first0",  int'(ifC.firstHit[0]), monExp.f0);
        chk("sb_first1",  int'(ifC.firstHit[1]), monExp.f1);
        chk("sb_doneCyc", cyc, monExp.doneCyc);
        chk("sb_busyLow", int'(ifC.busy), 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    ifA.start = 1'b0; ifB.start = 1'b0; ifC.start = 1'b0;
    ifA.entX[0] = 10'd100; ifA.entY[0] = 10'd100; ifA.entRX[0] = 8'd5; ifA.entRY[0] = 8'd5;
    ifA.obsX[0] = 10'd110; ifA.obsY[0] = 10'd100; ifA.obsRX[0] = 8'd5; ifA.obsRY[0] = 8'd5;
    ifA.obsExists = 1'b1;
    ifB.entX[0] = 10'd100; ifB.entY[0] = 10'd100; ifB.entRX[0] = 8'd5; ifB.entRY[0] = 8'd5;
    ifB.obsX[0] = 10'd110; ifB.obsY[0] = 10'd100; ifB.obsRX[0] = 8'd5; ifB.obsRY[0] = 8'd5;
    ifB.obsExists = 1'b1;
    setEnt(0, 600, 600, 3);
    setEnt(1, 700, 700, 3);
    farObs();

    // Reset state
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    chk("rst_busy",    int'(ifC.busy), 0);
    chk("rst_done",    int'(ifC.done), 0);
    chk("rst_overrun", int'(ifC.overrun), 0);
    chk("rst_mask",    int'(ifC.hitMask), 0);
    chk("rst_first0",  int'(ifC.firstHit[0]), 0);
    chk("rst_maskA",   int'(ifA.hitMask), 0);
    reset_l = 1'b1;

    // 1x1 touching edges: inclusive hits, strict does not; done two cycles on
    @(negedge sysClk);
    ifA.start = 1'b1; ifB.start = 1'b1;
    @(posedge sysClk);
    #1;
    ifA.start = 1'b0; ifB.start = 1'b0;
    chk("t1_busyA", int'(ifA.busy), 1);
    @(negedge sysClk);
    chk("t1_doneEarly", int'(ifA.done), 0);
    @(negedge sysClk);
    chk("t1_doneA",  int'(ifA.done), 1);
    chk("t1_maskA",  int'(ifA.hitMask), 1);
    chk("t1_firstA", int'(ifA.firstHit[0]), 0);
    chk("t1_doneB",  int'(ifB.done), 1);
    chk("t1_maskB",  int'(ifB.hitMask), 0);
    @(negedge sysClk);
    chk("t1_donePulse", int'(ifA.done), 0);

    // Lowest live overlapping obstacle wins; dead slot 3 is skipped
    farObs();
    setEnt(0, 50, 50, 4);
    setEnt(1, 600, 600, 3);
    setObs(3, 55, 50, 2);
    setObs(7, 55, 50, 2);
    setObs(12, 55, 50, 2);
    ifC.obsExists[3] = 1'b0;
    @(negedge sysClk);
    startC();
    waitDoneC("t2", 1'b1, 0, 0, 0);
    chk("t2_mask",   int'(ifC.hitMask), 1);
    chk("t2_first0", int'(ifC.firstHit[0]), 7);

    // Extreme coordinates and radii: no wrap in distance or radius sum
    farObs();
    ifC.obsExists = 16'h0001;
    setEnt(0, 0, 0, 255);
    setObs(0, 1023, 0, 255);
    @(negedge sysClk);
    startC();
    waitDoneC("t3a", 1'b0, 0, 0, 0);
    chk("t3a_mask", int'(ifC.hitMask), 0);
    setObs(0, 509, 0, 255);
    @(negedge sysClk);
    startC();
    waitDoneC("t3b", 1'b0, 0, 0, 0);
    chk("t3b_mask", int'(ifC.hitMask), 1);
    setObs(0, 511, 0, 255);
    @(negedge sysClk);
    startC();
    waitDoneC("t3c", 1'b0, 0, 0, 0);
    chk("t3c_mask", int'(ifC.hitMask), 0);

    // Two entities; previous results held throughout the following scan
    farObs();
    setEnt(0, 100, 100, 3);
    setEnt(1, 600, 600, 3);
    setObs(2, 100, 100, 3);
    setObs(5, 300, 300, 3);
    @(negedge sysClk);
    startC();
    waitDoneC("t4a", 1'b0, 0, 0, 0);
    chk("t4a_mask", int'(ifC.hitMask), 1);
    setEnt(1, 300, 300, 3);
    @(negedge sysClk);
    startC();
    waitDoneC("t4b", 1'b1, 1, 2, 0);
    chk("t4b_mask",   int'(ifC.hitMask), 3);
    chk("t4b_first1", int'(ifC.firstHit[1]), 5);
    chk("t4b_first0", int'(ifC.firstHit[0]), 2);

    // Start during scan gives one overrun pulse; start in DONE chains a scan
    @(negedge sysClk);
    startC();
    acc = cyc;
    repeat (3) @(negedge sysClk);
    chk("t5_cycAlign", cyc, acc + 2);
    ifC.start = 1'b1;
    @(posedge sysClk);
    #1;
    ifC.start = 1'b0;
    @(negedge sysClk);
    chk("t5_overrun", int'(ifC.overrun), 1);
    @(negedge sysClk);
    chk("t5_overrunPulse", int'(ifC.overrun), 0);
    waitDoneC("t5a", 1'b0, 0, 0, 0);
    startC();
    chk("t5_rebusy", int'(ifC.busy), 1);
    waitDoneC("t5b", 1'b0, 0, 0, 0);

    // Asynchronous reset mid-scan clears outputs at once; clean rescan after
    @(negedge sysClk);
    startC();
    repeat (5) @(posedge sysClk);
    #2;
    reset_l = 1'b0;
    #1;
    chk("t6_busy",   int'(ifC.busy), 0);
    chk("t6_mask",   int'(ifC.hitMask), 0);
    chk("t6_first0", int'(ifC.firstHit[0]), 0);
    chk("t6_first1", int'(ifC.firstHit[1]), 0);
    sbq.delete();
    @(negedge sysClk);
    reset_l = 1'b1;
    @(negedge sysClk);
    startC();
    waitDoneC("t6", 1'b0, 0, 0, 0);
    chk("t6_reMask",   int'(ifC.hitMask), 3);
    chk("t6_reFirst1", int'(ifC.firstHit[1]), 5);

    repeat (3) @(negedge sysClk);
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire
